demux_dispatcher_mxn: RTL and testbench

- Registered 1-to-M demultiplexer with enabler. It is the distribution-side counterpart of the M-channel select multiplexer.
- Accepts one N-bit word per handshake, steers it to the output channel named by in_select, and holds it there until that channel's consumer takes it.
- Sits between a single producer (e.g. a register-file read or writeback bus) and M lane consumers.

---
 rtl/mux_pkg.sv | 29 ++
 rtl/demux_channel_slot.sv | 55 +++++
 rtl/demux_dispatcher_mxn.sv | 101 ++++++++++
 tb/tb_demux_dispatcher_mxn.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// ============================================================================
// Module  : mux_pkg
// Brief   : Shared types and helpers for the select multiplexer / demux pair.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam int DROP_CNT_W = 8;

    typedef enum logic [0:0] {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_t;

    // ceil(log2(m)) with a floor of 1 so a single-channel build still has a select bit
    function automatic int sel_width(input int m);
        int w;
        w = 1;
        while ((32'd1 << w) < m) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux_channel_slot.sv
// ============================================================================
// Module  : demux_channel_slot
// Brief   : One output channel: single-entry holding register with EMPTY/FULL FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_channel_slot
    import mux_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [N-1:0] wr_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         can_accept
);

    ch_state_t    r_state;
    ch_state_t    w_next_state;
    logic [N-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CH_EMPTY;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (wr_en) begin
                r_data <= wr_data;
            end
        end
    end

    // A write while FULL replaces the word; that is only legal when popped this cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CH_EMPTY: if (wr_en)                  w_next_state = CH_FULL;
            CH_FULL:  if (out_ready && !wr_en)    w_next_state = CH_EMPTY;
            default:                              w_next_state = CH_EMPTY;
        endcase
    end

    assign out_valid  = (r_state == CH_FULL);
    assign out_data   = r_data;
    assign can_accept = !out_valid || out_ready;

endmodule

`default_nettype wire

// File: rtl/demux_dispatcher_mxn.sv
// ============================================================================
// Module  : demux_dispatcher_mxn
// Brief   : Registered 1-to-M demultiplexer with enabler and ready pass-through.
//           Optional drop counter for out-of-range selects: DEMUX_DROP_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_dispatcher_mxn
    import mux_pkg::*;
#(
    parameter  int M     = 4,   // channels, 1..128
    parameter  int N     = 8,   // bits per channel
    localparam int SEL_W = sel_width(M)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enabler,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_select,
    input  logic [N-1:0]          in_data,
    output logic [M-1:0]          out_valid,
    input  logic [M-1:0]          out_ready,
    output logic [M-1:0][N-1:0]   out_data,
    output logic                  busy
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  drop_pulse
`endif
);

    logic [M-1:0] w_can_accept;
    logic [M-1:0] w_wr_en;
    logic         w_hit;
    logic         w_sel_can;

    // Decode by comparison so a select beyond M never indexes past the vectors
    always_comb begin
        w_hit     = 1'b0;
        w_sel_can = 1'b0;
        w_wr_en   = '0;
        for (int i = 0; i < M; i++) begin
            if (in_select == SEL_W'(i)) begin
                w_hit      = 1'b1;
                w_sel_can  = w_can_accept[i];
                w_wr_en[i] = in_valid && enabler && w_can_accept[i];
            end
        end
    end

    assign in_ready = enabler && (!w_hit || w_sel_can);
    assign busy     = |out_valid;

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_slot
            demux_channel_slot #(
                .N (N)
            ) u_slot (
                .clk        (clk),
                .rst        (rst),
                .wr_en      (w_wr_en[gi]),
                .wr_data    (in_data),
                .out_ready  (out_ready[gi]),
                .out_valid  (out_valid[gi]),
                .out_data   (out_data[gi]),
                .can_accept (w_can_accept[gi])
            );
        end
    endgenerate

`ifdef DEMUX_DROP_CNT_EN
    logic                  w_drop;
    logic [DROP_CNT_W-1:0] r_drop_count;
    logic                  r_drop_pulse;

    assign w_drop = in_valid && in_ready && !w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_count != {DROP_CNT_W{1'b1}})) begin
                r_drop_count <= r_drop_count + DROP_CNT_W'(1);
            end
        end
    end

    assign drop_count = r_drop_count;
    assign drop_pulse = r_drop_pulse;
`else
    // Out-of-range words are accepted and discarded with no record kept
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_dispatcher_mxn.sv
// ============================================================================
// Module  : tb_demux_dispatcher_mxn
// Brief   : Directed and scoreboard checks for demux_dispatcher_mxn (M=4 and M=3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_dispatcher_mxn;

    logic clk;
    logic rst;

    // M=4 instance
    logic            enabler, in_valid, in_ready, busy;
    logic [1:0]      in_select;
    logic [7:0]      in_data;
    logic [3:0]      out_valid, out_ready;
    logic [3:0][7:0] out_data;

    // M=3 instance
    logic            e3, v3, rdy3, busy3;
    logic [1:0]      sel3;
    logic [7:0]      d3;
    logic [2:0]      ov3, ordy3;
    logic [2:0][7:0] od3;

`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] dc4, dc3;
    logic       dp4, dp3;
`endif

    int tests  = 0;
    int failed = 0;

    demux_dispatcher_mxn #(.M(4), .N(8)) dut (
        .clk(clk), .rst(rst), .enabler(enabler), .in_valid(in_valid),
        .in_ready(in_ready), .in_select(in_select), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
`ifdef DEMUX_DROP_CNT_EN
        , .drop_count(dc4), .drop_pulse(dp4)
`endif
    );

    demux_dispatcher_mxn #(.M(3), .N(8)) dut3 (
        .clk(clk), .rst(rst), .enabler(e3), .in_valid(v3),
        .in_ready(rdy3), .in_select(sel3), .in_data(d3),
        .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
        .busy(busy3)
`ifdef DEMUX_DROP_CNT_EN
        , .drop_count(dc3), .drop_pulse(dp3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); rst = 1'b0; #1;
        tests++; if (out_valid !== 4'b0000) begin failed++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
        tests++; if (out_data !== 32'h0) begin failed++; $display("FAIL reset_data got=%h exp=0", out_data); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        // fill channel 2, then reset with a transfer pending
        in_valid = 1'b1; in_select = 2'd2; in_data = 8'h77; tick();
        tests++; if (out_valid !== 4'b0100) begin failed++; $display("FAIL fill2_valid got=%b exp=0100", out_valid); end
        in_select = 2'd0; in_data = 8'h99; rst = 1'b1; tick();
        rst = 1'b0; in_valid = 1'b0; #1;
        tests++; if (out_valid !== 4'b0000) begin failed++; $display("FAIL midreset_valid got=%b exp=0000", out_valid); end
        tests++; if (out_data !== 32'h0) begin failed++; $display("FAIL midreset_data got=%h exp=0", out_data); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        enabler = 1'b0; #1;
        tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL midreset_ready_en0 got=%b exp=0", in_ready); end
        enabler = 1'b1; #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL midreset_ready_en1 got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_channel();
        in_valid = 1'b1; in_select = 2'd1; in_data = 8'hA5; out_ready = 4'b0000; #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL sc_ready0 got=%b exp=1", in_ready); end
        tick(); in_data = 8'h3C; #1;
        tests++; if (out_valid !== 4'b0010) begin failed++; $display("FAIL sc_valid got=%b exp=0010", out_valid); end
        tests++; if (out_data[1] !== 8'hA5) begin failed++; $display("FAIL sc_data got=%h exp=a5", out_data[1]); end
        tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL sc_ready_full got=%b exp=0", in_ready); end
        tick();
        tests++; if (out_data[1] !== 8'hA5) begin failed++; $display("FAIL sc_stall_data got=%h exp=a5", out_data[1]); end
        out_ready = 4'b0010; #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL sc_ready_pass got=%b exp=1", in_ready); end
        tick(); in_valid = 1'b0; out_ready = 4'b0000; #1;
        tests++; if (out_valid !== 4'b0010) begin failed++; $display("FAIL sc_replace_valid got=%b exp=0010", out_valid); end
        tests++; if (out_data[1] !== 8'h3C) begin failed++; $display("FAIL sc_replace_data got=%h exp=3c", out_data[1]); end
        out_ready = 4'b1111; tick(); out_ready = 4'b0000; #1;
        tests++; if (out_valid !== 4'b0000) begin failed++; $display("FAIL sc_drain got=%b exp=0000", out_valid); end
        tests++; if (out_data[1] !== 8'h3C) begin failed++; $display("FAIL sc_retain got=%h exp=3c", out_data[1]); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_select = 2'(i); in_data = 8'h10 + 8'(i); #1;
            tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0; #1;
        tests++; if (out_valid !== 4'hF) begin failed++; $display("FAIL b2b_valid got=%h exp=f", out_valid); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (out_data[i] !== 8'h10 + 8'(i)) begin failed++; $display("FAIL b2b_data%0d got=%h exp=%h", i, out_data[i], 8'h10 + 8'(i)); end
        end
        out_ready = 4'hF; tick(); out_ready = 4'h0; #1;
        tests++; if (out_valid !== 4'h0) begin failed++; $display("FAIL b2b_pop_valid got=%h exp=0", out_valid); end
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL b2b_pop_busy got=%b exp=0", busy); end
    endtask

    task automatic test_enabler();
        enabler = 1'b1; in_valid = 1'b1; in_select = 2'd0; in_data = 8'h55; tick();
        enabler = 1'b0; in_data = 8'h66; #1;
        tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL en_ready_off got=%b exp=0", in_ready); end
        tick();
        tests++; if (out_valid !== 4'b0001 || out_data[0] !== 8'h55) begin failed++; $display("FAIL en_hold got=%b/%h exp=0001/55", out_valid, out_data[0]); end
        out_ready = 4'b0001; #1;
        tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL en_ready_drain got=%b exp=0", in_ready); end
        tick(); out_ready = 4'b0000; #1;
        tests++; if (out_valid !== 4'b0000) begin failed++; $display("FAIL en_drained got=%b exp=0000", out_valid); end
        enabler = 1'b1; #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL en_ready_on got=%b exp=1", in_ready); end
        tick(); in_valid = 1'b0; #1;
        tests++; if (out_valid !== 4'b0001 || out_data[0] !== 8'h66) begin failed++; $display("FAIL en_resume got=%b/%h exp=0001/66", out_valid, out_data[0]); end
        out_ready = 4'b1111; tick(); out_ready = 4'b0000; #1;
    endtask

    task automatic test_out_of_range();
        e3 = 1'b1; v3 = 1'b1; sel3 = 2'd3; d3 = 8'hFF; ordy3 = 3'b000; #1;
        tests++; if (rdy3 !== 1'b1) begin failed++; $display("FAIL oor_ready got=%b exp=1", rdy3); end
        tick(); v3 = 1'b0; #1;
        tests++; if (ov3 !== 3'b000) begin failed++; $display("FAIL oor_valid got=%b exp=000", ov3); end
`ifdef DEMUX_DROP_CNT_EN
        tests++; if (dc3 !== 8'd1) begin failed++; $display("FAIL oor_count got=%0d exp=1", dc3); end
        tests++; if (dp3 !== 1'b1) begin failed++; $display("FAIL oor_pulse got=%b exp=1", dp3); end
        tick();
        tests++; if (dp3 !== 1'b0) begin failed++; $display("FAIL oor_pulse_end got=%b exp=0", dp3); end
        v3 = 1'b1;
        for (int i = 1; i < 300; i++) tick();
        v3 = 1'b0; #1;
        tests++; if (dc3 !== 8'd255) begin failed++; $display("FAIL oor_sat got=%0d exp=255", dc3); end
        tick();
        tests++; if (dp3 !== 1'b0) begin failed++; $display("FAIL oor_sat_pulse got=%b exp=0", dp3); end
`endif
        v3 = 1'b1; sel3 = 2'd2; d3 = 8'h42; tick(); v3 = 1'b0; #1;
        tests++; if (ov3 !== 3'b100 || od3[2] !== 8'h42) begin failed++; $display("FAIL m3_inrange got=%b/%h exp=100/42", ov3, od3[2]); end
        tests++; if (busy3 !== 1'b1) begin failed++; $display("FAIL m3_busy got=%b exp=1", busy3); end
    endtask

    task automatic test_random();
        logic [3:0]      mv;
        logic [3:0][7:0] md;
        logic            exp_rdy;
        rst = 1'b1; in_valid = 1'b0; out_ready = 4'h0; tick(); rst = 1'b0;
        mv = '0; md = '0;
        for (int c = 0; c < 10000; c++) begin
            enabler   = ($urandom_range(0, 7) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_select = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            #1;
            exp_rdy = enabler && (!mv[in_select] || out_ready[in_select]);
            tests++; if (in_ready !== exp_rdy) begin failed++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
            tests++; if (out_valid !== mv) begin failed++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, mv); end
            for (int i = 0; i < 4; i++) begin
                if (mv[i]) begin
                    tests++; if (out_data[i] !== md[i]) begin failed++; $display("FAIL rnd_data c=%0d ch=%0d got=%h exp=%h", c, i, out_data[i], md[i]); end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (in_valid && exp_rdy && in_select == 2'(i)) begin
                    mv[i] = 1'b1; md[i] = in_data;
                end else if (mv[i] && out_ready[i]) begin
                    mv[i] = 1'b0;
                end
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 4'h0;
    endtask

    initial begin
        rst = 1'b1; enabler = 1'b1; in_valid = 1'b0; in_select = '0; in_data = '0; out_ready = '0;
        e3 = 1'b1; v3 = 1'b0; sel3 = '0; d3 = '0; ordy3 = '0;
        tick(); tick(); rst = 1'b0;
        test_reset();
        test_single_channel();
        test_back_to_back();
        test_enabler();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
